// File: rtl/stroke_sequencer_n.sv
// stroke_sequencer_n: four-stroke cycle tracker for NUM_CYL cylinders driven by crank events and CKP phase.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   on                    enable; low forces IDLE on the next edge
//   crank_tick            single-cycle crank tooth pulse (also feeds the watchdog)
//   crank_changed         crank counter changed this cycle; evt = crank_tick & crank_changed
//   ckp                   CKP phase level (1: cylinder 0 at INTAKE, 0: at COMPRESSION)
//   stroke                per-cylinder stroke code at [2i+1:2i] (00 IN, 01 CMP, 10 CMB, 11 EXH)
//   allow_injection       bit i high while cylinder i is in INTAKE
//   allow_ignition        bit i high while cylinder i is in COMBUSTION
//   fic_on, ic_on, synced high while in RUN
//   sync_err              one-cycle pulse on loss of sync
// Optional feature: define HUST_EFI_CKP_CHECK_EN to require ckp=1 on the event that wraps base 11->00.
module stroke_sequencer_n #(
  parameter int          NUM_CYL          = 4,
  parameter int          TICKS_PER_STROKE = 1,
  parameter logic [15:0] FIRE_OFS         = 16'h00B4,
  parameter int          TIMEOUT_CYC      = 1000000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 on,
  input  logic                 crank_tick,
  input  logic                 crank_changed,
  input  logic                 ckp,
  output logic [2*NUM_CYL-1:0] stroke,
  output logic [NUM_CYL-1:0]   allow_injection,
  output logic [NUM_CYL-1:0]   allow_ignition,
  output logic                 fic_on,
  output logic                 ic_on,
  output logic                 synced,
  output logic                 sync_err
);
  localparam int TCW = (TICKS_PER_STROKE > 1) ? $clog2(TICKS_PER_STROKE) : 1;
  localparam int WDW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TCW-1:0] TC_LAST = TCW'(TICKS_PER_STROKE - 1);
  localparam logic [WDW-1:0] WD_MAX  = WDW'(TIMEOUT_CYC);
  typedef enum logic [1:0] {IDLE, START, RUN} state_t;
  state_t               state_q, state_d;
  logic [1:0]           base_q, base_d;
  logic [TCW-1:0]       tcnt_q, tcnt_d;
  logic [WDW-1:0]       wd_q, wd_d, wd_inc;
  logic                 evt, wrap, timeout, ckp_bad, err_d, run_d;
  logic [2*NUM_CYL-1:0] stroke_d;
  logic [NUM_CYL-1:0]   inj_d, ign_d;
  function automatic logic [1:0] cyl_stroke(input logic [1:0] b, input int i);
    return b + FIRE_OFS[2*i +: 2];
  endfunction
  assign evt     = crank_tick & crank_changed;
  // last event of the current stroke: base advances on this one
  assign wrap    = evt && (tcnt_q == TC_LAST);
  assign wd_inc  = (wd_q == WD_MAX) ? wd_q : wd_q + 1'b1;
  // a tick in the limit cycle clears the watchdog instead of timing out
  assign timeout = !crank_tick && (wd_inc == WD_MAX);
`ifdef HUST_EFI_CKP_CHECK_EN
  // cylinder 0 re-enters INTAKE on the 11->00 wrap, so CKP must agree
  assign ckp_bad = wrap && (base_q == 2'b11) && !ckp;
`else
  assign ckp_bad = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    tcnt_d  = tcnt_q;
    wd_d    = wd_q;
    err_d   = 1'b0;
    if (!on) begin
      state_d = IDLE;
      base_d  = 2'b00;
      tcnt_d  = '0;
      wd_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = START;
          wd_d    = '0;
        end
        START: begin
          wd_d = '0;
          if (evt) begin
            base_d  = ckp ? 2'b00 : 2'b01;
            tcnt_d  = '0;
            state_d = RUN;
          end
        end
        RUN: begin
          wd_d = crank_tick ? '0 : wd_inc;
          if (timeout || ckp_bad) begin
            err_d   = 1'b1;
            state_d = START;
            wd_d    = '0;
          end else if (evt) begin
            tcnt_d = wrap ? '0 : tcnt_q + 1'b1;
            base_d = wrap ? base_q + 2'd1 : base_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
  // outputs are registered from next-state values so they track the state register exactly
  always_comb begin
    run_d    = (state_d == RUN);
    stroke_d = '0;
    inj_d    = '0;
    ign_d    = '0;
    for (int i = 0; i < NUM_CYL; i++) begin
      stroke_d[2*i +: 2] = run_d ? cyl_stroke(base_d, i) : 2'b00;
      inj_d[i]           = run_d && (cyl_stroke(base_d, i) == 2'b00);
      ign_d[i]           = run_d && (cyl_stroke(base_d, i) == 2'b10);
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      base_q          <= 2'b00;
      tcnt_q          <= '0;
      wd_q            <= '0;
      stroke          <= '0;
      allow_injection <= '0;
      allow_ignition  <= '0;
      fic_on          <= 1'b0;
      ic_on           <= 1'b0;
      synced          <= 1'b0;
      sync_err        <= 1'b0;
    end else begin
      state_q         <= state_d;
      base_q          <= base_d;
      tcnt_q          <= tcnt_d;
      wd_q            <= wd_d;
      stroke          <= stroke_d;
      allow_injection <= inj_d;
      allow_ignition  <= ign_d;
      fic_on          <= run_d;
      ic_on           <= run_d;
      synced          <= run_d;
      sync_err        <= err_d;
    end
  end
endmodule

// File: tb/tb_stroke_sequencer_n.sv
// tb_stroke_sequencer_n: scoreboard bench for stroke_sequencer_n (identity and default firing offsets, tick divide by 3).
module tb_stroke_sequencer_n;
  logic clk = 1'b0, reset_n, on, crank_tick, crank_changed, ckp;
  logic [7:0] stroke_a, stroke_b;
  logic [3:0] inj_a, inj_b, ign_a, ign_b;
  logic fic_a, fic_b, ic_a, ic_b, syn_a, syn_b, err_a, err_b;
  int cyc = 0, checks = 0, passes = 0;
  typedef struct {int tag; int dut; string name; logic [18:0] v;} exp_t;
  exp_t q[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  stroke_sequencer_n #(.NUM_CYL(4), .TICKS_PER_STROKE(1), .FIRE_OFS(16'h00E4), .TIMEOUT_CYC(10)) dut_a (
    .clk(clk), .reset_n(reset_n), .on(on), .crank_tick(crank_tick), .crank_changed(crank_changed), .ckp(ckp),
    .stroke(stroke_a), .allow_injection(inj_a), .allow_ignition(ign_a),
    .fic_on(fic_a), .ic_on(ic_a), .synced(syn_a), .sync_err(err_a));
  stroke_sequencer_n #(.NUM_CYL(4), .TICKS_PER_STROKE(3), .TIMEOUT_CYC(10)) dut_b (
    .clk(clk), .reset_n(reset_n), .on(on), .crank_tick(crank_tick), .crank_changed(crank_changed), .ckp(ckp),
    .stroke(stroke_b), .allow_injection(inj_b), .allow_ignition(ign_b),
    .fic_on(fic_b), .ic_on(ic_b), .synced(syn_b), .sync_err(err_b));
  function automatic logic [18:0] pat(input int b, input bit r, input bit e, input logic [7:0] ofs);
    logic [7:0] st;
    logic [3:0] inj, ign;
    logic [1:0] s;
    st = '0;
    inj = '0;
    ign = '0;
    for (int i = 0; i < 4; i++) begin
      s = 2'(b + int'(ofs[2*i +: 2]));
      st[2*i +: 2] = s;
      inj[i] = (s == 2'b00);
      ign[i] = (s == 2'b10);
    end
    return r ? {st, inj, ign, 3'b111, e} : {18'b0, e};
  endfunction
  task automatic ex(input int d, input string n, input int b, input bit r, input bit e, input int lag = 1);
    exp_t x;
    x.tag = cyc + lag;
    x.dut = d;
    x.name = n;
    x.v = pat(b, r, e, d ? 8'hB4 : 8'hE4);
    q.push_back(x);
  endtask
  task automatic drive(input logic o, input logic t, input logic c, input logic k);
    on = o;
    crank_tick = t;
    crank_changed = c;
    ckp = k;
  endtask
  initial begin
    exp_t x;
    logic [18:0] act;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].tag <= cyc) begin
        x = q.pop_front();
        act = x.dut ? {stroke_b, inj_b, ign_b, fic_b, ic_b, syn_b, err_b}
                    : {stroke_a, inj_a, ign_a, fic_a, ic_a, syn_a, err_a};
        checks++;
        if (act === x.v) passes++;
        else $display("FAIL %s: got %b expected %b", x.name, act, x.v);
      end
    end
  end
  initial begin
    int div_t[7] = '{1, 1, 1, 1, 1, 1, 1};
    int div_c[7] = '{0, 1, 1, 1, 1, 1, 1};
    int div_b[7] = '{0, 0, 0, 1, 1, 1, 2};
    reset_n = 1'b0;
    drive(0, 0, 0, 0);
    @(negedge clk);
    ex(0, "reset_a", 0, 0, 0);
    ex(1, "reset_b", 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    drive(1, 0, 0, 1); ex(0, "idle_to_start", 0, 0, 0); @(negedge clk);
    drive(1, 1, 1, 1);
    q.push_back('{cyc + 1, 0, "sync_ckp1", {8'b11_10_01_00, 4'b0001, 4'b0100, 3'b111, 1'b0}});
    @(negedge clk);
    for (int b = 1; b <= 4; b++) begin
      drive(1, 1, 1, 1); ex(0, $sformatf("advance_%0d", b % 4), b % 4, 1, 0); @(negedge clk);
    end
    drive(1, 1, 0, 1); ex(0, "tick_nochg", 0, 1, 0); @(negedge clk);
    drive(0, 1, 1, 1); ex(0, "abort_evt", 0, 0, 0); @(negedge clk);
    drive(1, 0, 0, 0); ex(0, "start_ckp0", 0, 0, 0); @(negedge clk);
    drive(1, 1, 1, 0); ex(0, "sync_ckp0", 1, 1, 0); @(negedge clk);
    for (int k = 1; k <= 9; k++) begin
      drive(1, 0, 0, 0); ex(0, $sformatf("wd_wait_%0d", k), 1, 1, 0); @(negedge clk);
    end
    drive(1, 0, 0, 0); ex(0, "wd_timeout", 0, 0, 1); @(negedge clk);
    drive(1, 0, 0, 1); ex(0, "wd_start", 0, 0, 0); @(negedge clk);
    drive(1, 1, 1, 1); ex(0, "wd_resync", 0, 1, 0); @(negedge clk);
    for (int k = 1; k <= 9; k++) begin
      drive(1, 0, 0, 1); ex(0, $sformatf("wd2_wait_%0d", k), 0, 1, 0); @(negedge clk);
    end
    drive(1, 1, 0, 1); ex(0, "tick_at_limit", 0, 1, 0); @(negedge clk);
    for (int b = 1; b <= 3; b++) begin
      drive(1, 1, 1, 1); ex(0, $sformatf("pre_wrap_%0d", b), b, 1, 0); @(negedge clk);
    end
    drive(1, 1, 1, 0);
`ifdef HUST_EFI_CKP_CHECK_EN
    ex(0, "ckp_wrap_err", 0, 0, 1); @(negedge clk);
    drive(1, 0, 0, 1); ex(0, "ckp_wrap_start", 0, 0, 0);
`else
    ex(0, "ckp_wrap_nochk", 0, 1, 0);
`endif
    @(negedge clk);
    drive(0, 0, 0, 1); ex(0, "off", 0, 0, 0); @(negedge clk);
    drive(1, 0, 0, 1); ex(0, "start2", 0, 0, 0); @(negedge clk);
    drive(1, 1, 1, 1); ex(0, "sync_a", 0, 1, 0); ex(1, "sync_b", 0, 1, 0); @(negedge clk);
    drive(1, 0, 0, 1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    ex(0, "async_rst_a", 0, 0, 0, 0);
    ex(1, "async_rst_b", 0, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    drive(1, 0, 0, 1); ex(0, "post_rst_a", 0, 0, 0); ex(1, "post_rst_b", 0, 0, 0); @(negedge clk);
    drive(1, 0, 0, 1); ex(0, "needs_resync", 0, 0, 0); @(negedge clk);
    drive(1, 1, 1, 1); ex(0, "resync_a", 0, 1, 0); ex(1, "div_sync", 0, 1, 0); @(negedge clk);
    for (int k = 0; k < 7; k++) begin
      drive(1, div_t[k][0], div_c[k][0], 1);
      ex(1, $sformatf("div_step_%0d", k), div_b[k], 1, 0);
      @(negedge clk);
    end
    drive(0, 0, 0, 1); ex(1, "div_off", 0, 0, 0); @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() == 0) passes++;
    else $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
